axim_read_control: RTL and testbench
====================================

Name: axim_read_control

Overview:
AXI read-channel master that is the counterpart of the burst write controller on the SDRAM AXI test path. On a rising edge of an asynchronous start trigger it issues one read burst from a fixed word address. It then accepts the data beats and checks each beat against the incrementing pattern the writer stores, starting at DATA_INIT. It reports done, pass/fail and an error count for board-level LED/debug readback.

Parameters:
BURST_SIZE, 32, beats per burst (1..256); arlen = BURST_SIZE-1
DATA_INIT, 16'd100, expected value of the first beat; each following beat expects +1, wrapping mod 2^16
START_ADDR, 25'd0, word address driven on araddr

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
start_triger  in  1  asynchronous start request (push-button/switch); acts on its rising edge
axi_arready_in  in  1  AR channel ready from slave
axi_arvalid_out  out  1  AR channel valid
axi_arlen_out  out  8  burst length minus one, constant BURST_SIZE-1
axi_araddr_out  out  25  word address, constant START_ADDR
axi_rvalid_in  in  1  R channel valid from slave
axi_rdata_in  in  16  read data
axi_rlast_in  in  1  last beat marker
axi_rresp_in  in  2  read response; 2'b00 = OKAY
axi_rready_out  out  1  R channel ready
rd_busy_out  out  1  high from AR issue until burst completion
rd_done_out  out  1  one-cycle pulse at burst completion
rd_pass_out  out  1  level; 1 = last burst had zero errors; valid after done
rd_err_cnt_out  out  8  count of erroneous beats in the last burst, saturating at 255

Behaviour:
- Reset values: arvalid 0, rready 0, busy 0, done 0, pass 0, err_cnt 0, state IDLE. Sync flops are cleared to 0.
- Start sync: a 3-flop chain (meta, 1d, 2d); det = 1d & ~2d.
- start_triger first sampled high at edge E1. det is high after E2. arvalid rises at E3.
- States: IDLE, ADDR, DATA.
- IDLE: on det, the following all take effect on the same edge:
  - arvalid<=1, busy<=1, pass<=0, err_cnt<=0
  - expected<=DATA_INIT, beat_cnt<=BURST_SIZE-1
  - next state ADDR
- det while not in IDLE is ignored; no queuing.
- ADDR: hold arvalid, araddr and arlen stable until arready is sampled high. On that edge: arvalid<=0, rready<=1, next state DATA.
  - rready is never high before the AR handshake completes.
  - arready high in the same cycle arvalid first rises counts as the handshake.
- DATA: a beat is accepted on each edge where rvalid & rready. Per beat:
  - Beat is erroneous if any of the following holds: rdata != expected; rresp != 0; rlast != (beat_cnt == 0).
  - An erroneous beat increments err_cnt by 1 (saturating at 255).
  - expected<=expected+1 (16-bit wrap); beat_cnt<=beat_cnt-1.
- Termination: an accepted beat with beat_cnt==0 OR rlast==1 ends the burst. An early rlast therefore terminates without hanging.
  - On that edge: rready<=0, busy<=0, state IDLE.
  - done<=1 for exactly one cycle.
  - pass<=1 only if err_cnt, including the current beat's result, is 0.
- rvalid low: nothing changes; no timeout.
- pass and err_cnt hold until the next accepted start.
- Reset mid-burst: the next edge returns all outputs to reset values. The outstanding slave beats are not drained; the system resets the slave together with this block.
- BURST_SIZE=1: arlen=0, single beat that must carry rlast=1.

Test Plan:
- Slave returns 32 beats 100..131, rresp 0, rlast on beat 32, arready immediate -> arvalid high one cycle at E3, araddr 0, arlen 31; done pulse after beat 32; pass=1, err_cnt=0.
- Same burst, beat 5 returns 999 and beat 20 returns rresp=2'b10 -> err_cnt=2, pass=0.
- rlast asserted on beat 10 -> burst ends after beat 10, done pulses, err_cnt=1, pass=0, rready 0; no hang.
- arready held low for 7 cycles, then rvalid toggled every other cycle -> arvalid stays high for 8 cycles with address stable; rready 0 until AR handshake; all 32 beats accepted; pass=1.
- Second start_triger edge mid-burst, then reset asserted at beat 12 -> the second start is ignored; after reset, arvalid=rready=busy=0, pass=0, err_cnt=0; a new start then runs a full passing burst.
- start_triger glitch shorter than one clk, or held high for 100 cycles -> at most one burst per rising edge; a constant-high level does not retrigger.

Source files
------------

// File: rtl/axim_read_control.sv
// AXI read-channel master for the SDRAM test path.
// Issues one fixed-address read burst per rising edge of start_triger and
// checks the returned beats against the writer's incrementing pattern.
module axim_read_control #(
    parameter int          BURST_SIZE = 32,
    parameter logic [15:0] DATA_INIT  = 16'd100,
    parameter logic [24:0] START_ADDR = 25'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_triger,
    input  logic        axi_arready_in,
    output logic        axi_arvalid_out,
    output logic [7:0]  axi_arlen_out,
    output logic [24:0] axi_araddr_out,
    input  logic        axi_rvalid_in,
    input  logic [15:0] axi_rdata_in,
    input  logic        axi_rlast_in,
    input  logic [1:0]  axi_rresp_in,
    output logic        axi_rready_out,
    output logic        rd_busy_out,
    output logic        rd_done_out,
    output logic        rd_pass_out,
    output logic [7:0]  rd_err_cnt_out
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_SIZE - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state, state_nxt;
    logic        arvalid, arvalid_nxt;
    logic        rready, rready_nxt;
    logic        busy, busy_nxt;
    logic        done, done_nxt;
    logic        pass, pass_nxt;
    logic [7:0]  err_cnt, err_cnt_nxt;
    logic [15:0] expected, expected_nxt;
    logic [7:0]  beat_cnt, beat_cnt_nxt;

    logic        start_meta, start_1d, start_2d;
    logic        start_det;
    logic        beat_err;
    logic [7:0]  err_upd;

    assign start_det = start_1d & ~start_2d;

    // Synchronise the asynchronous trigger and keep one extra stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            start_meta <= 1'b0;
            start_1d   <= 1'b0;
            start_2d   <= 1'b0;
        end else begin
            start_meta <= start_triger;
            start_1d   <= start_meta;
            start_2d   <= start_1d;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            expected <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            arvalid  <= arvalid_nxt;
            rready   <= rready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            pass     <= pass_nxt;
            err_cnt  <= err_cnt_nxt;
            expected <= expected_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Next-state logic: address issue, beat checking and burst termination
    always_comb begin
        state_nxt    = state;
        arvalid_nxt  = arvalid;
        rready_nxt   = rready;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        pass_nxt     = pass;
        err_cnt_nxt  = err_cnt;
        expected_nxt = expected;
        beat_cnt_nxt = beat_cnt;

        beat_err = (axi_rdata_in != expected) || (axi_rresp_in != 2'b00) ||
                   (axi_rlast_in != (beat_cnt == 8'd0));
        err_upd  = (beat_err && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;

        case (state)
            IDLE: begin
                if (start_det) begin
                    arvalid_nxt  = 1'b1;
                    busy_nxt     = 1'b1;
                    pass_nxt     = 1'b0;
                    err_cnt_nxt  = '0;
                    expected_nxt = DATA_INIT;
                    beat_cnt_nxt = LAST_BEAT;
                    state_nxt    = ADDR;
                end
            end
            ADDR: begin
                if (axi_arready_in) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (axi_rvalid_in && rready) begin
                    err_cnt_nxt  = err_upd;
                    expected_nxt = expected + 16'd1;
                    beat_cnt_nxt = beat_cnt - 8'd1;
                    // An early rlast also ends the burst so a short slave cannot hang us
                    if (beat_cnt == 8'd0 || axi_rlast_in) begin
                        rready_nxt = 1'b0;
                        busy_nxt   = 1'b0;
                        done_nxt   = 1'b1;
                        pass_nxt   = (err_upd == 8'd0);
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign axi_arvalid_out = arvalid;
    assign axi_arlen_out   = LAST_BEAT;
    assign axi_araddr_out  = START_ADDR;
    assign axi_rready_out  = rready;
    assign rd_busy_out     = busy;
    assign rd_done_out     = done;
    assign rd_pass_out     = pass;
    assign rd_err_cnt_out  = err_cnt;

endmodule

// File: tb/tb_axim_read_control.sv
// Directed bench for axim_read_control with a simple scripted read slave.
module tb_axim_read_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_triger = 1'b0;
    logic        axi_arready_in = 1'b0;
    logic        axi_arvalid_out;
    logic [7:0]  axi_arlen_out;
    logic [24:0] axi_araddr_out;
    logic        axi_rvalid_in = 1'b0;
    logic [15:0] axi_rdata_in = '0;
    logic        axi_rlast_in = 1'b0;
    logic [1:0]  axi_rresp_in = '0;
    logic        axi_rready_out;
    logic        rd_busy_out;
    logic        rd_done_out;
    logic        rd_pass_out;
    logic [7:0]  rd_err_cnt_out;

    int checks = 0;
    int failures = 0;

    logic [15:0] bd [0:31];
    logic [1:0]  br [0:31];
    logic        bl [0:31];

    axim_read_control #(
        .BURST_SIZE (32),
        .DATA_INIT  (16'd100),
        .START_ADDR (25'd0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_triger    (start_triger),
        .axi_arready_in  (axi_arready_in),
        .axi_arvalid_out (axi_arvalid_out),
        .axi_arlen_out   (axi_arlen_out),
        .axi_araddr_out  (axi_araddr_out),
        .axi_rvalid_in   (axi_rvalid_in),
        .axi_rdata_in    (axi_rdata_in),
        .axi_rlast_in    (axi_rlast_in),
        .axi_rresp_in    (axi_rresp_in),
        .axi_rready_out  (axi_rready_out),
        .rd_busy_out     (rd_busy_out),
        .rd_done_out     (rd_done_out),
        .rd_pass_out     (rd_pass_out),
        .rd_err_cnt_out  (rd_err_cnt_out)
    );

    always #5 clk = ~clk;

    // Clean pattern: 100..131, OKAY, rlast on the 32nd beat
    task automatic fill_good();
        for (int i = 0; i < 32; i++) begin
            bd[i] = 16'(100 + i);
            br[i] = 2'b00;
            bl[i] = (i == 31);
        end
    endtask

    // Raise the trigger and wait (bounded) for arvalid; trigger is left high
    task automatic issue(output bit ok);
        ok = 1'b0;
        start_triger = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (axi_arvalid_out) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Present beats k0.. until n_stop beats are taken, done is seen, or the budget runs out
    task automatic serve(input int k0, input int n_stop, input bit toggle, input int max_cyc,
                         output int accepted, output bit done_seen);
        int  k;
        bit  rr;
        k = k0;
        accepted = 0;
        done_seen = 1'b0;
        for (int c = 0; c < max_cyc && !done_seen && k < n_stop; c++) begin
            if (!toggle || (c % 2) == 0) begin
                axi_rvalid_in = 1'b1;
                axi_rdata_in  = bd[k];
                axi_rresp_in  = br[k];
                axi_rlast_in  = bl[k];
            end else begin
                axi_rvalid_in = 1'b0;
            end
            rr = axi_rready_out;
            @(negedge clk);
            if (axi_rvalid_in && rr) begin
                k++;
                accepted++;
            end
            if (rd_done_out) done_seen = 1'b1;
        end
        axi_rvalid_in = 1'b0;
        axi_rlast_in  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({axi_arvalid_out, axi_rready_out, rd_busy_out, rd_done_out, rd_pass_out} !== 5'b0 ||
            rd_err_cnt_out !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: arv/rr/busy/done/pass=%b%b%b%b%b err=%0d required all 0",
                     axi_arvalid_out, axi_rready_out, rd_busy_out, rd_done_out, rd_pass_out, rd_err_cnt_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int acc;
        bit dn;
        fill_good();
        axi_arready_in = 1'b1;
        start_triger = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (axi_arvalid_out !== 1'b0) begin
            failures++;
            $display("FAIL arvalid_before_E3: got %b required 0", axi_arvalid_out);
        end
        start_triger = 1'b0;
        @(negedge clk);
        checks++;
        if (axi_arvalid_out !== 1'b1 || rd_busy_out !== 1'b1 || axi_rready_out !== 1'b0) begin
            failures++;
            $display("FAIL arvalid_at_E3: arv=%b busy=%b rr=%b required 1 1 0",
                     axi_arvalid_out, rd_busy_out, axi_rready_out);
        end
        checks++;
        if (axi_araddr_out !== 25'd0 || axi_arlen_out !== 8'd31) begin
            failures++;
            $display("FAIL ar_fields: addr=%0d len=%0d required 0 31", axi_araddr_out, axi_arlen_out);
        end
        @(negedge clk);
        checks++;
        if (axi_arvalid_out !== 1'b0 || axi_rready_out !== 1'b1) begin
            failures++;
            $display("FAIL ar_handshake: arv=%b rr=%b required 0 1", axi_arvalid_out, axi_rready_out);
        end
        serve(0, 32, 1'b0, 100, acc, dn);
        checks++;
        if (acc !== 32 || dn !== 1'b1) begin
            failures++;
            $display("FAIL basic_beats: accepted=%0d done=%b required 32 1", acc, dn);
        end
        checks++;
        if (rd_pass_out !== 1'b1 || rd_err_cnt_out !== 8'd0 || rd_busy_out !== 1'b0 || axi_rready_out !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: pass=%b err=%0d busy=%b rr=%b required 1 0 0 0",
                     rd_pass_out, rd_err_cnt_out, rd_busy_out, axi_rready_out);
        end
        @(negedge clk);
        checks++;
        if (rd_done_out !== 1'b0 || rd_pass_out !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse_width: done=%b pass=%b required 0 1", rd_done_out, rd_pass_out);
        end
    endtask

    task automatic test_errors();
        int acc;
        bit dn;
        bit ok;
        fill_good();
        bd[4]  = 16'd999;
        br[19] = 2'b10;
        axi_arready_in = 1'b1;
        issue(ok);
        start_triger = 1'b0;
        serve(0, 32, 1'b0, 100, acc, dn);
        checks++;
        if (!ok || acc !== 32 || dn !== 1'b1 || rd_err_cnt_out !== 8'd2 || rd_pass_out !== 1'b0) begin
            failures++;
            $display("FAIL data_resp_errors: ok=%b acc=%0d done=%b err=%0d pass=%b required 1 32 1 2 0",
                     ok, acc, dn, rd_err_cnt_out, rd_pass_out);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_early_last();
        int acc;
        bit dn;
        bit ok;
        fill_good();
        bl[9] = 1'b1;
        axi_arready_in = 1'b1;
        issue(ok);
        start_triger = 1'b0;
        serve(0, 32, 1'b0, 100, acc, dn);
        checks++;
        if (!ok || acc !== 10 || dn !== 1'b1 || rd_err_cnt_out !== 8'd1 || rd_pass_out !== 1'b0 ||
            axi_rready_out !== 1'b0 || rd_busy_out !== 1'b0) begin
            failures++;
            $display("FAIL early_rlast: ok=%b acc=%0d done=%b err=%0d pass=%b rr=%b busy=%b required 1 10 1 1 0 0 0",
                     ok, acc, dn, rd_err_cnt_out, rd_pass_out, axi_rready_out, rd_busy_out);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_arready_stall();
        int acc;
        bit dn;
        bit ok;
        int high_cnt;
        bit bad_ar;
        fill_good();
        axi_arready_in = 1'b0;
        issue(ok);
        start_triger = 1'b0;
        high_cnt = 0;
        bad_ar = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (axi_arvalid_out) high_cnt++;
            if (axi_rready_out || axi_araddr_out !== 25'd0 || axi_arlen_out !== 8'd31) bad_ar = 1'b1;
            if (i == 7) axi_arready_in = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!ok || high_cnt !== 8 || bad_ar) begin
            failures++;
            $display("FAIL ar_stall: ok=%b arvalid_cycles=%0d rr_or_addr_bad=%b required 1 8 0",
                     ok, high_cnt, bad_ar);
        end
        checks++;
        if (axi_arvalid_out !== 1'b0 || axi_rready_out !== 1'b1) begin
            failures++;
            $display("FAIL ar_stall_handshake: arv=%b rr=%b required 0 1", axi_arvalid_out, axi_rready_out);
        end
        serve(0, 32, 1'b1, 200, acc, dn);
        checks++;
        if (acc !== 32 || dn !== 1'b1 || rd_pass_out !== 1'b1 || rd_err_cnt_out !== 8'd0) begin
            failures++;
            $display("FAIL toggled_rvalid: acc=%0d done=%b pass=%b err=%0d required 32 1 1 0",
                     acc, dn, rd_pass_out, rd_err_cnt_out);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_retrigger_and_reset();
        int acc;
        int acc2;
        bit dn;
        bit ok;
        int ar_hits;
        fill_good();
        bd[2] = 16'd7;
        axi_arready_in = 1'b1;
        issue(ok);
        start_triger = 1'b0;
        serve(0, 6, 1'b0, 50, acc, dn);
        ar_hits = 0;
        start_triger = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (axi_arvalid_out) ar_hits++;
        end
        start_triger = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (axi_arvalid_out) ar_hits++;
        end
        checks++;
        if (!ok || acc !== 6 || dn || ar_hits !== 0 || rd_busy_out !== 1'b1 || axi_rready_out !== 1'b1) begin
            failures++;
            $display("FAIL start_ignored_busy: ok=%b acc=%0d done=%b ar_hits=%0d busy=%b rr=%b required 1 6 0 0 1 1",
                     ok, acc, dn, ar_hits, rd_busy_out, axi_rready_out);
        end
        serve(6, 12, 1'b0, 50, acc2, dn);
        checks++;
        if (acc2 !== 6 || dn || rd_err_cnt_out !== 8'd1) begin
            failures++;
            $display("FAIL mid_burst_count: acc=%0d done=%b err=%0d required 6 0 1", acc2, dn, rd_err_cnt_out);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({axi_arvalid_out, axi_rready_out, rd_busy_out, rd_pass_out} !== 4'b0 || rd_err_cnt_out !== 8'd0) begin
            failures++;
            $display("FAIL mid_burst_reset: arv/rr/busy/pass=%b%b%b%b err=%0d required 0000 0",
                     axi_arvalid_out, axi_rready_out, rd_busy_out, rd_pass_out, rd_err_cnt_out);
        end
        reset = 1'b0;
        @(negedge clk);
        fill_good();
        issue(ok);
        start_triger = 1'b0;
        serve(0, 32, 1'b0, 100, acc, dn);
        checks++;
        if (!ok || acc !== 32 || dn !== 1'b1 || rd_pass_out !== 1'b1 || rd_err_cnt_out !== 8'd0) begin
            failures++;
            $display("FAIL after_reset_burst: ok=%b acc=%0d done=%b pass=%b err=%0d required 1 32 1 1 0",
                     ok, acc, dn, rd_pass_out, rd_err_cnt_out);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_trigger_shapes();
        int acc;
        bit dn;
        bit ok;
        int ar_hits;
        // Glitch between clock edges is never sampled
        @(negedge clk);
        #1 start_triger = 1'b1;
        #2 start_triger = 1'b0;
        ar_hits = 0;
        repeat (12) begin
            @(negedge clk);
            if (axi_arvalid_out || rd_busy_out) ar_hits++;
        end
        checks++;
        if (ar_hits !== 0) begin
            failures++;
            $display("FAIL glitch_trigger: active_cycles=%0d required 0", ar_hits);
        end
        // Long high level: one burst, no retrigger
        fill_good();
        axi_arready_in = 1'b1;
        issue(ok);
        serve(0, 32, 1'b0, 100, acc, dn);
        checks++;
        if (!ok || acc !== 32 || dn !== 1'b1 || rd_pass_out !== 1'b1) begin
            failures++;
            $display("FAIL held_trigger_burst: ok=%b acc=%0d done=%b pass=%b required 1 32 1 1",
                     ok, acc, dn, rd_pass_out);
        end
        ar_hits = 0;
        repeat (60) begin
            @(negedge clk);
            if (axi_arvalid_out || rd_busy_out) ar_hits++;
        end
        start_triger = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (axi_arvalid_out || rd_busy_out) ar_hits++;
        end
        checks++;
        if (ar_hits !== 0 || rd_pass_out !== 1'b1) begin
            failures++;
            $display("FAIL held_trigger_retrigger: active_cycles=%0d pass=%b required 0 1", ar_hits, rd_pass_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_early_last();
        test_arready_stall();
        test_retrigger_and_reset();
        test_trigger_shapes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
